// File: rtl/sat_iter_ctrl.sv
// -----------------------------------------------------------------------------
// sat_iter_ctrl
//
// Upstream sequencing controller for the variable-processing-element array of
// the SAT annealer. It runs the solve loop:
//   SETTLE : wait SETTLE_CYC cycles for SATISFY to ripple down the systolic chain
//   CHECK  : sample SATISFY; finish if satisfied or if the budget is spent
//   UPDATE : pulse the update enable of one variable (round-robin), count sweeps
//   FIN    : report DONE/SOLVED, then return to IDLE
// STOCHASTIC_MODE is held for the first STOCH_ITERS sweeps of a solve.
//
// Ports
//   i_clk             system clock, rising edge
//   i_rst_n           asynchronous active-low reset
//   i_start           single-cycle solve request, honoured only in IDLE
//   i_abort           forces return to IDLE from any non-IDLE state
//   i_max_iter        sweep budget, sampled on accepted start
//   i_stoch_iters     number of leading stochastic sweeps, sampled on start
//   i_satisfy         AND-chained satisfy from the last PE of the array
//   o_vul_en          one-hot per-variable update-enable pulse
//   o_stochastic_mode selects stochastic update in all PEs
//   o_busy            solve in progress
//   o_done            solve finished, held until the next accepted start
//   o_solved          valid with o_done: 1 = satisfied, 0 = budget exhausted
//   o_iter_cnt        completed sweeps
// -----------------------------------------------------------------------------
module sat_iter_ctrl #(
    parameter int NUM_VAR    = 60,
    parameter int SETTLE_CYC = 4,
    parameter int CNT_W      = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_abort,
    input  logic [CNT_W-1:0]   i_max_iter,
    input  logic [CNT_W-1:0]   i_stoch_iters,
    input  logic               i_satisfy,
    output logic [NUM_VAR-1:0] o_vul_en,
    output logic               o_stochastic_mode,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_solved,
    output logic [CNT_W-1:0]   o_iter_cnt
);

    localparam int VIDX_W = (NUM_VAR > 1) ? $clog2(NUM_VAR) : 1;

    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [VIDX_W-1:0] VIDX_LAST   = VIDX_W'(NUM_VAR - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_UPDATE = 3'd3;
    localparam logic [2:0] S_FIN    = 3'd4;

    // State and output registers
    logic [2:0]         r_state;
    logic [7:0]         r_settle_cnt;
    logic [VIDX_W-1:0]  r_var_idx;
    logic [CNT_W-1:0]   r_iter_cnt;
    logic [CNT_W-1:0]   r_max_iter;
    logic [CNT_W-1:0]   r_stoch_lim;
    logic [NUM_VAR-1:0] r_vul_en;
    logic               r_stoch;
    logic               r_busy;
    logic               r_done;
    logic               r_solved;

    // Next-state values
    logic [2:0]         w_state_next;
    logic [7:0]         w_settle_next;
    logic [VIDX_W-1:0]  w_var_idx_next;
    logic [CNT_W-1:0]   w_iter_next;
    logic [CNT_W-1:0]   w_max_next;
    logic [CNT_W-1:0]   w_stoch_lim_next;
    logic [NUM_VAR-1:0] w_vul_next;
    logic               w_stoch_next;
    logic               w_busy_next;
    logic               w_done_next;
    logic               w_solved_next;

    // Sweep count the stochastic compare is evaluated against; a fresh start
    // compares against the cleared count rather than the stale one.
    logic [CNT_W-1:0]   w_iter_cmp;
    logic [NUM_VAR-1:0] w_onehot;

    // Decode of the current variable index into its update-enable bit
    for (genvar gi = 0; gi < NUM_VAR; gi++) begin : g_onehot
        assign w_onehot[gi] = (r_var_idx == VIDX_W'(gi));
    end

    always_comb begin
        w_state_next     = r_state;
        w_settle_next    = r_settle_cnt;
        w_var_idx_next   = r_var_idx;
        w_iter_next      = r_iter_cnt;
        w_max_next       = r_max_iter;
        w_stoch_lim_next = r_stoch_lim;
        w_vul_next       = '0;
        w_busy_next      = r_busy;
        w_done_next      = r_done;
        w_solved_next    = r_solved;
        w_iter_cmp       = r_iter_cnt;

        if ((r_state != S_IDLE) && i_abort) begin
            // Abort keeps the sweep count for post-mortem inspection
            w_state_next  = S_IDLE;
            w_settle_next = '0;
            w_busy_next   = 1'b0;
            w_done_next   = 1'b0;
            w_solved_next = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // An abort in the same cycle suppresses the start
                    if (i_start && !i_abort) begin
                        w_state_next     = S_SETTLE;
                        w_settle_next    = '0;
                        w_var_idx_next   = '0;
                        w_iter_next      = '0;
                        w_max_next       = i_max_iter;
                        w_stoch_lim_next = i_stoch_iters;
                        w_busy_next      = 1'b1;
                        w_done_next      = 1'b0;
                        w_solved_next    = 1'b0;
                        w_iter_cmp       = '0;
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt == SETTLE_LAST) begin
                        w_state_next  = S_CHECK;
                        w_settle_next = '0;
                    end else begin
                        w_settle_next = r_settle_cnt + 8'd1;
                    end
                end
                S_CHECK: begin
                    if (i_satisfy) begin
                        w_state_next  = S_FIN;
                        w_busy_next   = 1'b0;
                        w_done_next   = 1'b1;
                        w_solved_next = 1'b1;
                    end else if (r_iter_cnt == r_max_iter) begin
                        // Budget spent; this compare is also what keeps the
                        // sweep counter from ever wrapping.
                        w_state_next  = S_FIN;
                        w_busy_next   = 1'b0;
                        w_done_next   = 1'b1;
                        w_solved_next = 1'b0;
                    end else begin
                        w_state_next = S_UPDATE;
                        w_vul_next   = w_onehot;
                    end
                end
                S_UPDATE: begin
                    w_state_next = S_SETTLE;
                    if (r_var_idx == VIDX_LAST) begin
                        w_var_idx_next = '0;
                        w_iter_next    = r_iter_cnt + CNT_W'(1);
                    end else begin
                        w_var_idx_next = r_var_idx + VIDX_W'(1);
                    end
                end
                S_FIN: begin
                    w_state_next = S_IDLE;
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_busy_next  = 1'b0;
                end
            endcase
        end

        // Uses the count of the current cycle, so the mode drops one cycle
        // after the sweep counter passes the stochastic limit.
        w_stoch_next = w_busy_next && (w_iter_cmp < w_stoch_lim_next);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_settle_cnt <= '0;
            r_var_idx    <= '0;
            r_iter_cnt   <= '0;
            r_max_iter   <= '0;
            r_stoch_lim  <= '0;
            r_vul_en     <= '0;
            r_stoch      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_solved     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_settle_cnt <= w_settle_next;
            r_var_idx    <= w_var_idx_next;
            r_iter_cnt   <= w_iter_next;
            r_max_iter   <= w_max_next;
            r_stoch_lim  <= w_stoch_lim_next;
            r_vul_en     <= w_vul_next;
            r_stoch      <= w_stoch_next;
            r_busy       <= w_busy_next;
            r_done       <= w_done_next;
            r_solved     <= w_solved_next;
        end
    end

    assign o_vul_en          = r_vul_en;
    assign o_stochastic_mode = r_stoch;
    assign o_busy            = r_busy;
    assign o_done            = r_done;
    assign o_solved          = r_solved;
    assign o_iter_cnt        = r_iter_cnt;

endmodule

// File: doc/sat_iter_ctrl.md
Name: sat_iter_ctrl

Overview:
- Upstream sequencing controller for the variable-processing-element array of the SAT annealer.
- Runs the solve loop: waits for clause evaluation to settle, then samples the array-wide SATISFY.
- If SATISFY is low, pulses the per-variable update enable (VUL_EN) of one variable at a time, round-robin, and counts full sweeps as iterations.
- Drives STOCHASTIC_MODE for the first STOCH_ITERS iterations, and reports solved or timeout to the host.

Parameters:
- NUM_VAR, 60, number of variable PEs; width of VUL_EN.
- SETTLE_CYC, 4, cycles to wait for SATISFY to propagate through the systolic chain before sampling; legal range 1..255.
- CNT_W, 16, width of iteration counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- START  in  1  single-cycle solve request; honoured only in IDLE.
- ABORT  in  1  forces return to IDLE from any state.
- MAX_ITER  in  CNT_W  iteration budget; sampled on accepted START.
- STOCH_ITERS  in  CNT_W  number of leading iterations run in stochastic mode; sampled on accepted START.
- SATISFY  in  1  AND-chained satisfy from the array (last PE of the systolic chain).
- VUL_EN  out  NUM_VAR  one-hot update-enable pulse to the variable PEs.
- STOCHASTIC_MODE  out  1  selects stochastic update in all PEs.
- BUSY  out  1  high while a solve is in progress.
- DONE  out  1  solve finished; held until next accepted START.
- SOLVED  out  1  valid with DONE; 1 = SATISFY observed, 0 = budget exhausted.
- ITER_CNT  out  CNT_W  completed sweeps.

Behaviour:
- All outputs are registered.
- Reset (async, RESET_N=0): state IDLE; VUL_EN=0, STOCHASTIC_MODE=0, BUSY=0, DONE=0, SOLVED=0, ITER_CNT=0; var_idx=0, settle counter=0.
- States and transitions:
  - IDLE -> SETTLE on START.
  - SETTLE: stays exactly SETTLE_CYC cycles, then -> CHECK.
  - CHECK: samples SATISFY for one cycle.
    - SATISFY=1 -> FIN with SOLVED=1.
    - Else, if ITER_CNT==MAX_ITER -> FIN with SOLVED=0.
    - Else -> UPDATE.
  - UPDATE: one cycle; VUL_EN[var_idx]=1, all other bits 0. var_idx increments.
    - If var_idx==NUM_VAR-1: var_idx wraps to 0 and ITER_CNT increments.
    - Then -> SETTLE.
  - FIN: one cycle; DONE=1, BUSY=0 registered, -> IDLE. DONE and SOLVED stay high in IDLE.
- START accepted in IDLE only; clears DONE, SOLVED, ITER_CNT and var_idx, latches MAX_ITER and STOCH_ITERS, sets BUSY.
  - BUSY is visible the cycle after START.
  - START while BUSY is ignored.
- Per-variable step period is SETTLE_CYC+2 cycles.
- Latency from START cycle t:
  - First CHECK at t+SETTLE_CYC+1.
  - DONE visible at t+SETTLE_CYC+2 if the first check passes.
- STOCHASTIC_MODE = BUSY and (ITER_CNT < STOCH_ITERS); registered, so it changes the cycle after ITER_CNT changes.
- Boundary conditions:
  - MAX_ITER=0: exactly one CHECK; no VUL_EN pulse ever.
  - STOCH_ITERS=0: STOCHASTIC_MODE never asserts.
  - STOCH_ITERS>=MAX_ITER: stochastic for the whole solve.
  - ITER_CNT never wraps: the CHECK compare terminates the solve at MAX_ITER.
  - ABORT, any state except IDLE: next cycle IDLE, VUL_EN=0, BUSY=0, STOCHASTIC_MODE=0, DONE=0, SOLVED=0; ITER_CNT holds its value.
  - ABORT and START in the same cycle: ABORT wins.
  - ABORT in IDLE: no effect.
  - SATISFY is ignored outside CHECK.
  - A SATISFY rise during an UPDATE cycle is not acted on before the following CHECK.
  - Reset asserted mid-solve: immediate return to reset values, including any VUL_EN pulse in flight.
- Invariant: VUL_EN is zero or one-hot at all times.

Test Plan:
All scenarios use NUM_VAR=4 and SETTLE_CYC=2, with START at cycle 0.
- SATISFY held at 1 -> BUSY high cycles 1-3, CHECK at 3, DONE=1 and SOLVED=1 at cycle 4, VUL_EN never nonzero, ITER_CNT=0.
- SATISFY=0, MAX_ITER=1, STOCH_ITERS=0 -> VUL_EN = 0001, 0010, 0100, 1000 at cycles 4, 8, 12, 16; ITER_CNT=1 at 17; DONE=1, SOLVED=0 at cycle 20.
- SATISFY=0 until it rises at cycle 9, MAX_ITER=5 -> pulses at cycles 4 and 8 only; CHECK at 11 passes; DONE=1, SOLVED=1 at 12; ITER_CNT=0.
- SATISFY=0, MAX_ITER=3, STOCH_ITERS=1 -> STOCHASTIC_MODE=1 from cycle 1 to 17 and drops at cycle 18 after ITER_CNT becomes 1; DONE at cycle 52 with ITER_CNT=3.
- ABORT at cycle 6 -> cycle 7 IDLE: BUSY=0, VUL_EN=0, DONE=0. START at cycle 10 re-runs cleanly, with the first pulse at cycle 14 on VUL_EN[0].
- START repeated at cycle 2 is ignored, and MAX_ITER changed mid-solve has no effect. Separately, RESET_N low at cycle 8 (during the UPDATE pulse) -> VUL_EN=0 immediately and all outputs at reset values.
